// File: rtl/cpu_cycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------------+
// | cpu_cycle_ctrl : MCS8 machine-cycle / processor-state sequencer (T1..T5, WAIT,   |
// | STOPPED). Macro CPU_WAIT_EN enables READY_I and the WAIT state. Revision 1.0     |
// +----------------------------------------------------------------------------------+
module cpu_cycle_ctrl (
  input  logic       CLK_I,
  input  logic       RSTN_I,
  input  logic       READY_I,
  input  logic       INT_I,
  input  logic       COND_I,
  input  logic       D_NOP_I,
  input  logic       D_HLT_I,
  input  logic       D_INC_I,
  input  logic       D_DCR_I,
  input  logic       D_ROT_I,
  input  logic       D_RETC_I,
  input  logic       D_ALUI_I,
  input  logic       D_RST_I,
  input  logic       D_LRI_I,
  input  logic       D_LMI_I,
  input  logic       D_RET_I,
  input  logic       D_JMPC_I,
  input  logic       D_CALC_I,
  input  logic       D_JMP_I,
  input  logic       D_CAL_I,
  input  logic       D_INP_I,
  input  logic       D_OUT_I,
  input  logic       D_ALUR_I,
  input  logic       D_ALUM_I,
  input  logic       D_LRR_I,
  input  logic       D_LRM_I,
  input  logic       D_LMR_I,
  output logic [2:0] STATE_O,
  output logic [1:0] CYCLE_O,
  output logic [1:0] CYC_NUM_O,
  output logic       IR_LD_O,
  output logic       PC_INC_O,
  output logic       INTACK_O,
  output logic       HALT_O
);

  typedef enum logic [2:0] {
    S_T1   = 3'b010,
    S_T1I  = 3'b110,
    S_T2   = 3'b100,
    S_WAIT = 3'b000,
    S_T3   = 3'b001,
    S_STOP = 3'b011,
    S_T4   = 3'b111,
    S_T5   = 3'b101
  } state_t;

  localparam logic [1:0] C_PCI = 2'b00;
  localparam logic [1:0] C_PCR = 2'b01;
  localparam logic [1:0] C_PCC = 2'b10;
  localparam logic [1:0] C_PCW = 2'b11;

  state_t     state_q, state_d;
  logic [1:0] cyc_type_q, cyc_type_d, cyc_num_q, cyc_num_d;
  logic       pend_q, pend_d, intack_q, intack_d;
  logic       irld_q, irld_d, pcinc_q, pcinc_d, halt_q, halt_d;
  logic       c1_long_q, c1_long_d, three_q, three_d;
  logic       c2_ext_q, c2_ext_d, c3_ext_q, c3_ext_d, c3_cnd_q, c3_cnd_d;
  logic [1:0] c2_type_q, c2_type_d, c3_type_q, c3_type_d;
  logic       w_ready, w_two, w_three, w_end, w_nxt;
  logic [1:0] w_nxt_type, w_c2_type;
  logic       w_unused_short;

`ifdef CPU_WAIT_EN
  assign w_ready = READY_I;
`else
  logic w_unused_ready;
  assign w_unused_ready = READY_I;
  assign w_ready        = 1'b1;
`endif

  // NOP/ROT/ALUR take the default cycle-1 path (end after T4) and need no decode.
  assign w_unused_short = D_NOP_I ^ D_ROT_I ^ D_ALUR_I;

  assign w_two     = D_ALUI_I | D_LRI_I | D_ALUM_I | D_LRM_I | D_LMR_I | D_INP_I | D_OUT_I;
  assign w_three   = D_LMI_I | D_JMP_I | D_CAL_I | D_JMPC_I | D_CALC_I;
  assign w_c2_type = (D_LMR_I | D_LMI_I) ? C_PCW : ((D_INP_I | D_OUT_I) ? C_PCC : C_PCR);

  always_comb begin
    state_d    = state_q;
    cyc_type_d = cyc_type_q;
    cyc_num_d  = cyc_num_q;
    intack_d   = intack_q;
    pend_d     = pend_q | INT_I;
    c1_long_d  = c1_long_q;
    three_d    = three_q;
    c2_ext_d   = c2_ext_q;
    c2_type_d  = c2_type_q;
    c3_ext_d   = c3_ext_q;
    c3_cnd_d   = c3_cnd_q;
    c3_type_d  = c3_type_q;
    w_end      = 1'b0;
    w_nxt      = 1'b0;
    w_nxt_type = C_PCR;

    // Strobes are only trusted at the end of T3 of cycle 1; capture the class there.
    if (state_q == S_T3 && cyc_num_q == 2'd1) begin
      c1_long_d = D_INC_I | D_DCR_I | D_LRR_I | D_RST_I | D_RET_I | (D_RETC_I & COND_I);
      three_d   = w_three;
      c2_ext_d  = D_ALUM_I | D_ALUI_I | D_LRM_I | D_LRI_I | D_INP_I;
      c2_type_d = w_c2_type;
      c3_ext_d  = D_JMP_I | D_CAL_I;
      c3_cnd_d  = D_JMPC_I | D_CALC_I;
      c3_type_d = D_LMI_I ? C_PCW : C_PCR;
    end

    unique case (state_q)
      S_T1, S_T1I: state_d = S_T2;
      S_T2, S_WAIT: state_d = w_ready ? S_T3 : S_WAIT;
      S_T3: begin
        if (cyc_num_q == 2'd1) begin
          if (D_HLT_I)                  state_d = S_STOP;
          else if (w_two | w_three)     begin w_nxt = 1'b1; w_nxt_type = w_c2_type; end
          else if (D_RETC_I && !COND_I) w_end = 1'b1;
          else                          state_d = S_T4;
        end else if (cyc_num_q == 2'd2) begin
          if (c2_ext_q)     state_d = S_T4;
          else if (three_q) begin w_nxt = 1'b1; w_nxt_type = c3_type_q; end
          else              w_end = 1'b1;
        end else begin
          if (c3_ext_q || (c3_cnd_q && COND_I)) state_d = S_T4;
          else                                  w_end = 1'b1;
        end
      end
      S_T4: begin
        if (cyc_num_q == 2'd1 && !c1_long_q) w_end = 1'b1;
        else                                 state_d = S_T5;
      end
      S_T5:   w_end = 1'b1;
      S_STOP: w_end = pend_q | INT_I;
    endcase

    if (w_nxt) begin
      state_d    = S_T1;
      cyc_num_d  = cyc_num_q + 2'd1;
      cyc_type_d = w_nxt_type;
      intack_d   = 1'b0;
    end
    if (w_end) begin
      cyc_num_d  = 2'd1;
      cyc_type_d = C_PCI;
      if (pend_q | INT_I) begin
        state_d  = S_T1I;
        intack_d = 1'b1;
        pend_d   = 1'b0;
      end else begin
        state_d  = S_T1;
        intack_d = 1'b0;
      end
    end
    if (state_d == S_STOP) intack_d = 1'b0;

    irld_d  = (state_d == S_T3) && (cyc_num_d == 2'd1);
    pcinc_d = (state_d == S_T3) &&
              (((cyc_num_d == 2'd1) && !intack_d) ||
               ((cyc_num_d != 2'd1) && (cyc_type_d == C_PCR)));
    halt_d  = (state_d == S_STOP);
  end

  always_ff @(posedge CLK_I) begin
    if (!RSTN_I) begin
      state_q    <= S_T1;
      cyc_type_q <= C_PCI;
      cyc_num_q  <= 2'd1;
      pend_q     <= 1'b0;
      intack_q   <= 1'b0;
      irld_q     <= 1'b0;
      pcinc_q    <= 1'b0;
      halt_q     <= 1'b0;
      c1_long_q  <= 1'b0;
      three_q    <= 1'b0;
      c2_ext_q   <= 1'b0;
      c2_type_q  <= C_PCR;
      c3_ext_q   <= 1'b0;
      c3_cnd_q   <= 1'b0;
      c3_type_q  <= C_PCR;
    end else begin
      state_q    <= state_d;
      cyc_type_q <= cyc_type_d;
      cyc_num_q  <= cyc_num_d;
      pend_q     <= pend_d;
      intack_q   <= intack_d;
      irld_q     <= irld_d;
      pcinc_q    <= pcinc_d;
      halt_q     <= halt_d;
      c1_long_q  <= c1_long_d;
      three_q    <= three_d;
      c2_ext_q   <= c2_ext_d;
      c2_type_q  <= c2_type_d;
      c3_ext_q   <= c3_ext_d;
      c3_cnd_q   <= c3_cnd_d;
      c3_type_q  <= c3_type_d;
    end
  end

  assign STATE_O   = state_q;
  assign CYCLE_O   = cyc_type_q;
  assign CYC_NUM_O = cyc_num_q;
  assign IR_LD_O   = irld_q;
  assign PC_INC_O  = pcinc_q;
  assign INTACK_O  = intack_q;
  assign HALT_O    = halt_q;

endmodule
`default_nettype wire
